maxnet_param: RTL and testbench



---
 rtl/maxnet_param.sv | 195 +++++++++++++++++++
 tb/tb_maxnet_param.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/maxnet_param.sv
// Parametrised Maxnet winner-take-all core: lateral inhibition with a programmable
// weight eps, iterated until at most one neuron survives or MAX_ITER iterations pass.
module maxnet_param #(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int FRAC     = 8,
    parameter int MAX_ITER = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [N*W-1:0]                  in_data,
    input  logic [W-1:0]                    eps,
    output logic                            ready,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(N)-1:0]            winner_idx,
    output logic [W-1:0]                    winner_val,
    output logic                            no_winner,
    output logic                            timeout,
    output logic [$clog2(MAX_ITER+1)-1:0]   iter_count
);

    localparam int IW  = $clog2(N);
    localparam int ITW = $clog2(MAX_ITER + 1);
    localparam int SW  = W + $clog2(N);
    localparam int PW  = W + SW;
    localparam int CW  = $clog2(N + 1);
    localparam logic [ITW-1:0] ITER_LIMIT = ITW'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q [N];
    logic [W-1:0]    a_d [N];
    logic [W-1:0]    eps_q, eps_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [ITW-1:0]  iter_q, iter_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [IW-1:0]   winner_idx_q, winner_idx_d;
    logic [W-1:0]    winner_val_q, winner_val_d;
    logic            no_winner_q, no_winner_d;
    logic            timeout_q, timeout_d;
    logic [ITW-1:0]  iter_count_q, iter_count_d;

    logic [SW-1:0]   sum_all;
    logic [CW-1:0]   nz_count;
    logic [IW-1:0]   best_idx;
    logic [W-1:0]    best_val;
    logic [SW-1:0]   diff [N];
    logic [PW-1:0]   prod [N];
    logic [PW-1:0]   dec  [N];
    logic [W-1:0]    a_upd [N];

    // Datapath shared by all states: total activation, survivor count, argmax
    // (strict > keeps the lowest index on ties) and the per-neuron inhibition step.
    always_comb begin
        sum_all  = '0;
        nz_count = '0;
        best_idx = '0;
        best_val = '0;
        for (int j = 0; j < N; j++) begin
            sum_all = sum_all + SW'(a_q[j]);
            if (a_q[j] != '0) begin
                nz_count = nz_count + CW'(1);
            end
            if (a_q[j] > best_val) begin
                best_val = a_q[j];
                best_idx = IW'(j);
            end
            diff[j] = sum_q - SW'(a_q[j]);
            prod[j] = PW'(eps_q) * PW'(diff[j]);
            dec[j]  = prod[j] >> FRAC;
            if (dec[j] >= PW'(a_q[j])) begin
                a_upd[j] = '0;
            end else begin
                a_upd[j] = a_q[j] - dec[j][W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        eps_d        = eps_q;
        sum_d        = sum_q;
        iter_d       = iter_q;
        done_d       = 1'b0;
        winner_idx_d = winner_idx_q;
        winner_val_d = winner_val_q;
        no_winner_d  = no_winner_q;
        timeout_d    = timeout_q;
        iter_count_d = iter_count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int j = 0; j < N; j++) begin
                        a_d[j] = in_data[j*W +: W];
                    end
                    eps_d        = eps;
                    iter_d       = '0;
                    winner_idx_d = '0;
                    winner_val_d = '0;
                    no_winner_d  = 1'b0;
                    timeout_d    = 1'b0;
                    iter_count_d = '0;
                    state_d      = S_SUM;
                end
            end
            S_SUM: begin
                sum_d   = sum_all;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                a_d     = a_upd;
                iter_d  = iter_q + ITW'(1);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (nz_count <= CW'(1) || iter_q == ITER_LIMIT) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SUM;
                end
            end
            S_DONE: begin
                // More than one survivor here can only mean the iteration limit hit.
                done_d       = 1'b1;
                winner_idx_d = best_idx;
                winner_val_d = best_val;
                no_winner_d  = (nz_count == '0);
                timeout_d    = (nz_count > CW'(1));
                iter_count_d = iter_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_SUM) || (state_d == S_UPDATE) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            for (int j = 0; j < N; j++) begin
                a_q[j] <= '0;
            end
            eps_q        <= '0;
            sum_q        <= '0;
            iter_q       <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            winner_idx_q <= '0;
            winner_val_q <= '0;
            no_winner_q  <= 1'b0;
            timeout_q    <= 1'b0;
            iter_count_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            eps_q        <= eps_d;
            sum_q        <= sum_d;
            iter_q       <= iter_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            winner_idx_q <= winner_idx_d;
            winner_val_q <= winner_val_d;
            no_winner_q  <= no_winner_d;
            timeout_q    <= timeout_d;
            iter_count_q <= iter_count_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign winner_idx = winner_idx_q;
    assign winner_val = winner_val_q;
    assign no_winner  = no_winner_q;
    assign timeout    = timeout_q;
    assign iter_count = iter_count_q;

endmodule

// File: tb/tb_maxnet_param.sv
// Directed bench for maxnet_param: a table of hand-computed runs plus sequences for
// start-while-busy, mid-run reset and back-to-back operation.
module tb_maxnet_param;

    localparam int N        = 4;
    localparam int W        = 16;
    localparam int FRAC     = 8;
    localparam int MAX_ITER = 32;
    localparam int LIMIT    = 200;
    localparam int NVEC     = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [W-1:0]   eps = '0;
    logic           ready, busy, done;
    logic [1:0]     winner_idx;
    logic [W-1:0]   winner_val;
    logic           no_winner, timeout;
    logic [5:0]     iter_count;

    int n_checks = 0;
    int n_miscompares = 0;

    typedef struct {
        string          tag;
        logic [N*W-1:0] in_vec;
        logic [W-1:0]   eps;
        int             exp_idx;
        int             exp_val;
        int             exp_nw;
        int             exp_to;
        int             exp_iter;
        int             exp_lat;
    } vec_t;

    vec_t vecs [NVEC];

    maxnet_param #(.N(N), .W(W), .FRAC(FRAC), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .eps(eps),
        .ready(ready), .busy(busy), .done(done), .winner_idx(winner_idx),
        .winner_val(winner_val), .no_winner(no_winner), .timeout(timeout),
        .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    task automatic checkValue(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits for ready, pulses start for one edge and returns #1 after the accept edge.
    task automatic applyStimulus(input logic [N*W-1:0] data, input logic [W-1:0] e);
        int guard = 0;
        @(negedge clk);
        while (!ready && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        in_data = data;
        eps     = e;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int inject_at, output int lat);
        lat = 0;
        while (!done && lat < LIMIT) begin
            if (lat == inject_at) begin
                in_data = pack4(0, 0, 0, 7);
                eps     = 16'h0100;
                start   = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            lat++;
        end
    endtask

    task automatic checkOutput(input vec_t v, input int lat);
        checkValue({v.tag, "_latency"},    lat,               v.exp_lat);
        checkValue({v.tag, "_winner_idx"}, int'(winner_idx),  v.exp_idx);
        checkValue({v.tag, "_winner_val"}, int'(winner_val),  v.exp_val);
        checkValue({v.tag, "_no_winner"},  int'(no_winner),   v.exp_nw);
        checkValue({v.tag, "_timeout"},    int'(timeout),     v.exp_to);
        checkValue({v.tag, "_iter_count"}, int'(iter_count),  v.exp_iter);
    endtask

    initial begin
        int lat;
        int done_seen;

        vecs[0] = '{"trace",   pack4(100, 80, 60, 40), 16'h0040, 0, 43,  0, 0, 4,  13};
        vecs[1] = '{"single3", pack4(0, 0, 0, 7),      16'h0040, 3, 7,   0, 0, 1,  4};
        vecs[2] = '{"tie_zero",pack4(100, 100, 0, 0),  16'h0100, 0, 0,   1, 0, 1,  4};
        vecs[3] = '{"stall",   pack4(50, 50, 0, 0),    16'h0040, 0, 3,   0, 1, 32, 97};
        vecs[4] = '{"allzero", pack4(0, 0, 0, 0),      16'h0040, 0, 0,   1, 0, 1,  4};
        vecs[5] = '{"eps0",    pack4(5, 9, 9, 1),      16'h0000, 1, 9,   0, 1, 32, 97};
        vecs[6] = '{"single1", pack4(0, 200, 0, 0),    16'h0100, 1, 200, 0, 0, 1,  4};
        vecs[7] = '{"half",    pack4(10, 40, 30, 0),   16'h0080, 1, 18,  0, 0, 2,  7};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkValue("reset_ready",      int'(ready),      1);
        checkValue("reset_busy",       int'(busy),       0);
        checkValue("reset_done",       int'(done),       0);
        checkValue("reset_winner_val", int'(winner_val), 0);
        checkValue("reset_iter_count", int'(iter_count), 0);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].in_vec, vecs[i].eps);
            checkValue({vecs[i].tag, "_busy_after_accept"}, int'(busy),       1);
            checkValue({vecs[i].tag, "_cleared_val"},       int'(winner_val), 0);
            checkValue({vecs[i].tag, "_cleared_iter"},      int'(iter_count), 0);
            waitDone(-1, lat);
            checkOutput(vecs[i], lat);
            @(posedge clk);
            #1 checkValue({vecs[i].tag, "_done_one_cycle"}, int'(done), 0);
        end

        $display("[TB] start while busy");
        applyStimulus(vecs[0].in_vec, vecs[0].eps);
        waitDone(4, lat);
        checkOutput(vecs[0], lat);

        $display("[TB] reset mid-run");
        applyStimulus(vecs[3].in_vec, vecs[3].eps);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checkValue("midreset_ready",      int'(ready),      1);
        checkValue("midreset_busy",       int'(busy),       0);
        checkValue("midreset_winner_val", int'(winner_val), 0);
        checkValue("midreset_iter_count", int'(iter_count), 0);
        rst = 1'b1;
        done_seen = 0;
        repeat (110) begin
            @(posedge clk);
            #1 if (done) done_seen++;
        end
        checkValue("midreset_no_done", done_seen, 0);
        applyStimulus(vecs[0].in_vec, vecs[0].eps);
        waitDone(-1, lat);
        checkOutput(vecs[0], lat);

        $display("[TB] back-to-back");
        checkValue("b2b_ready_in_done_cycle", int'(ready),      1);
        checkValue("b2b_hold_val",            int'(winner_val), 43);
        in_data = vecs[7].in_vec;
        eps     = vecs[7].eps;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkValue("b2b_done_dropped",  int'(done),       0);
        checkValue("b2b_cleared_val",   int'(winner_val), 0);
        checkValue("b2b_cleared_iter",  int'(iter_count), 0);
        waitDone(-1, lat);
        checkOutput(vecs[7], lat);
        repeat (3) @(posedge clk);
        #1 checkValue("b2b_hold_after", int'(winner_val), 18);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
        $finish;
    end

endmodule
